// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
// Frame records are sized for the largest supported digit count; smaller builds use the low slice.
package disp_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_IDX_W  = 3;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef struct packed {
        logic [MAX_DIGITS*DIGIT_W-1:0] data;
        logic [MAX_DIGITS-1:0]         blank;
        logic [MAX_DIGITS-1:0]         blink;
    } frame_t;

    localparam frame_t FRAME_RST = '{data: '0, blank: '1, blink: '0};

endpackage

// File: rtl/display_scan_ctrl_seven_seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module Seven_Seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared decoder, double-buffering frame
// loads so the active frame only changes at a frame boundary; applies per-digit blank/blink.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]         load_blank,
    input  logic [NUM_DIGITS-1:0]         load_blink,
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic                          pending,
    output logic                          frame_done
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]     pre;
    logic [IDX_W-1:0]     idx;
    logic [FC_W-1:0]      frame_cnt;
    logic                 blink_phase;
    frame_t               active;
    frame_t               shadow;
    frame_t               load_frame;
    logic [MAX_IDX_W-1:0] idx_ext;
    logic [DIGIT_W-1:0]   digit_hex;
    logic [6:0]           digit_seg;
    logic                 visible;
    logic                 tick;
    logic                 boundary;

    assign tick     = (pre == PRE_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // Widening idx lets the digit mux address the full-size frame record directly.
    assign idx_ext   = MAX_IDX_W'(idx);
    assign digit_hex = active.data[idx_ext*DIGIT_W +: DIGIT_W];
    assign visible   = !active.blank[idx_ext] && !(active.blink[idx_ext] && blink_phase);

    always_comb begin
        load_frame = FRAME_RST;
        load_frame.data[DIGIT_W*NUM_DIGITS-1:0] = load_data;
        load_frame.blank[NUM_DIGITS-1:0]        = load_blank;
        load_frame.blink[NUM_DIGITS-1:0]        = load_blink;
    end

    Seven_Seg u_seven_seg (
        .hex (digit_hex),
        .seg (digit_seg)
    );

    // load is a bare strobe with no ready: every asserted cycle is taken, the last one wins.
    // A load on the boundary cycle lands in shadow after the old shadow has moved to active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre         <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            active      <= FRAME_RST;
            shadow      <= FRAME_RST;
            pending     <= 1'b0;
            frame_done  <= 1'b0;
            an_out      <= '1;
            seg_out     <= SEG_OFF;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                idx <= boundary ? '0 : idx + 1'b1;
            end
            if (boundary) begin
                if (pending) begin
                    active <= shadow;
                end
                if (frame_cnt == FC_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (load) begin
                shadow  <= load_frame;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            frame_done <= boundary;
            an_out     <= ~(NUM_DIGITS'(1) << idx);
            seg_out    <= visible ? digit_seg : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  load_blank = '0;
    logic [3:0]  load_blink = '0;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int passes = 0;

    logic [3:0] obs_an [4];
    logic [6:0] obs_seg [4];
    bit         fd_ok;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_blank (load_blank),
        .load_blink (load_blink),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .pending    (pending),
        .frame_done (frame_done)
    );

    // Standard active-low hex font, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
            4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
            4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
            4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk);
        load       = 1'b1;
        load_data  = d;
        load_blank = bl;
        load_blink = bk;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        fd_ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fd_ok = 1;
                break;
            end
        end
        checks++;
        if (fd_ok) passes++;
        else $display("FAIL frame_done_timeout: no pulse within %0d cycles", budget);
    endtask

    // Called at the negedge where frame_done is high; grabs the middle of each digit slot.
    task automatic sample_frame();
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k % 4 == 2) begin
                obs_an[(k - 2) / 4]  = an_out;
                obs_seg[(k - 2) / 4] = seg_out;
            end
        end
    endtask

    task automatic observe_frame();
        wait_fd(40);
        sample_frame();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_load(16'h8888, 4'b0000, 4'b0000);
        repeat (5) @(negedge clk);
        checks++;
        if (pending !== 1'b1) $display("FAIL reset_pre_pending: got %b want 1", pending);
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (an_out !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an_out);
        else passes++;
        checks++;
        if (seg_out !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg_out);
        else passes++;
        checks++;
        if (pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", pending);
        else passes++;
        checks++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done);
        else passes++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k % 4 == 1) begin
                checks++;
                if (an_out !== an_of((k - 1) / 4))
                    $display("FAIL post_reset_an: k=%0d got %b want %b", k, an_out, an_of((k - 1) / 4));
                else passes++;
                checks++;
                if (seg_out !== 7'h7F) $display("FAIL post_reset_seg: k=%0d got %h want 7f", k, seg_out);
                else passes++;
            end
        end
    endtask

    task automatic test_single_load();
        int cnt;
        wait_fd(40);
        do_load(16'h3210, 4'b0000, 4'b0000);
        checks++;
        if (pending !== 1'b1) $display("FAIL single_pending_set: got %b want 1", pending);
        else passes++;
        observe_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_an[d] !== an_of(d)) $display("FAIL single_an: d=%0d got %b want %b", d, obs_an[d], an_of(d));
            else passes++;
            checks++;
            if (obs_seg[d] !== seg_of(4'(d))) $display("FAIL single_seg: d=%0d got %h want %h", d, obs_seg[d], seg_of(4'(d)));
            else passes++;
        end
        checks++;
        if (pending !== 1'b0) $display("FAIL single_pending_clr: got %b want 0", pending);
        else passes++;
        wait_fd(40);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (frame_done === 1'b1) break;
        end
        checks++;
        if (cnt !== 16) $display("FAIL frame_period: got %0d want 16", cnt);
        else passes++;
    endtask

    task automatic test_overwrite();
        wait_fd(40);
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'b0000);
        observe_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_seg[d] !== seg_of(4'h2)) $display("FAIL overwrite_seg: d=%0d got %h want %h", d, obs_seg[d], seg_of(4'h2));
            else passes++;
        end
        checks++;
        if (pending !== 1'b0) $display("FAIL overwrite_pending: got %b want 0", pending);
        else passes++;
    endtask

    task automatic test_boundary_collision();
        wait_fd(40);
        @(negedge clk);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        repeat (13) @(negedge clk);
        do_load(16'hBBBB, 4'b0000, 4'b0000);
        checks++;
        if (frame_done !== 1'b1) $display("FAIL collide_on_boundary: frame_done got %b want 1", frame_done);
        else passes++;
        checks++;
        if (pending !== 1'b1) $display("FAIL collide_pending: got %b want 1", pending);
        else passes++;
        sample_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_seg[d] !== seg_of(4'hA)) $display("FAIL collide_seg_a: d=%0d got %h want %h", d, obs_seg[d], seg_of(4'hA));
            else passes++;
        end
        checks++;
        if (pending !== 1'b1) $display("FAIL collide_pending_hold: got %b want 1", pending);
        else passes++;
        observe_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_seg[d] !== seg_of(4'hB)) $display("FAIL collide_seg_b: d=%0d got %h want %h", d, obs_seg[d], seg_of(4'hB));
            else passes++;
        end
        checks++;
        if (pending !== 1'b0) $display("FAIL collide_pending_clr: got %b want 0", pending);
        else passes++;
    endtask

    task automatic test_blink_blank();
        bit         vis0 [6];
        logic [6:0] exp0;
        vis0 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        reset_dut();
        do_load(16'h5555, 4'b0010, 4'b0001);
        for (int f = 0; f < 6; f++) begin
            observe_frame();
            exp0 = vis0[f] ? seg_of(4'h5) : 7'h7F;
            checks++;
            if (obs_seg[0] !== exp0) $display("FAIL blink_d0: frame=%0d got %h want %h", f, obs_seg[0], exp0);
            else passes++;
            checks++;
            if (obs_seg[1] !== 7'h7F) $display("FAIL blank_d1: frame=%0d got %h want 7f", f, obs_seg[1]);
            else passes++;
            for (int d = 2; d < 4; d++) begin
                checks++;
                if (obs_seg[d] !== seg_of(4'h5)) $display("FAIL steady_d%0d: frame=%0d got %h want %h", d, f, obs_seg[d], seg_of(4'h5));
                else passes++;
            end
        end
    endtask

    task automatic test_reset_pending();
        bit seen;
        wait_fd(40);
        do_load(16'h9999, 4'b0000, 4'b0000);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (an_out === 4'b1011) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) $display("FAIL rst_pend_idx2_timeout: an_out never reached 1011");
        else passes++;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (pending !== 1'b0) $display("FAIL rst_pend_pending: got %b want 0", pending);
        else passes++;
        for (int f = 0; f < 2; f++) begin
            observe_frame();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (obs_seg[d] !== 7'h7F) $display("FAIL rst_pend_seg: frame=%0d d=%0d got %h want 7f", f, d, obs_seg[d]);
                else passes++;
            end
            checks++;
            if (pending !== 1'b0) $display("FAIL rst_pend_pending_after: frame=%0d got %b want 0", f, pending);
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_single_load();
        test_overwrite();
        test_boundary_collision();
        test_blink_blank();
        test_reset_pending();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
